// File: rtl/hdmi_timing_gen_pkg.sv
// hdmi_timing_gen_pkg: shared video types, 720p timing defaults and HDMI pack field widths.
package hdmi_timing_gen_pkg;

    localparam int DEF_H_ACT  = 1280;
    localparam int DEF_V_ACT  = 720;
    localparam int DEF_H_FP   = 110;
    localparam int DEF_H_SYNC = 40;
    localparam int DEF_H_BP   = 220;
    localparam int DEF_V_FP   = 5;
    localparam int DEF_V_SYNC = 5;
    localparam int DEF_V_BP   = 20;

    localparam int RGB_W = 24;

    // Pack layout, MSB first: {clk, hsync, vsync, de, r, g, b, x, y}
    function automatic int pack_w(int x_w, int y_w);
        return 4 + RGB_W + x_w + y_w;
    endfunction

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_mode_e;

    // Element 0 is the leftmost bar (white)
    localparam logic [7:0][RGB_W-1:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/hdmi_timing_gen_pattern.sv
// video_pattern_rgb: registered test-pattern colour for the current timing counters.
module video_pattern_rgb
    import hdmi_timing_gen_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int HC_W  = 11,
    parameter int VC_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HC_W-1:0]   h_cnt,
    input  logic [VC_W-1:0]   v_cnt,
    input  logic              h_wrap,
    input  logic              de,
    input  logic [1:0]        mode,
    input  logic [RGB_W-1:0]  solid_rgb,
    output logic [RGB_W-1:0]  rgb
);

    localparam int BAR_W = H_ACT / 8;
    localparam int BP_W  = $clog2(BAR_W + 1);
    localparam logic [BP_W-1:0] BAR_LAST = BP_W'(BAR_W - 1);

    logic [BP_W-1:0]  bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    pat_mode_e        mode_e;

    // Bar counters track h_cnt, restarting with it so no divider is needed
    always_comb begin
        mode_e    = pat_mode_e'(mode);
        bar_px_d  = (h_wrap || bar_px_q == BAR_LAST) ? '0 : bar_px_q + 1'b1;
        bar_idx_d = h_wrap ? 3'd0 : (bar_px_q == BAR_LAST) ? bar_idx_q + 3'd1 : bar_idx_q;
        rgb_d     = !de                  ? '0 :
                    mode_e == PAT_SOLID  ? solid_rgb :
                    mode_e == PAT_BARS   ? BAR_RGB[bar_idx_q] :
                    mode_e == PAT_RAMP   ? {3{h_cnt[7:0]}} :
                    (h_cnt[5] ^ v_cnt[5]) ? '0 : 24'hFFFFFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            rgb_q     <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: free-running video timing with a built-in test pattern, emitting the HDMI pack stream.
module hdmi_timing_gen
    import hdmi_timing_gen_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_mode,
    input  logic [23:0] i_solid_rgb,
    output logic [pack_w($clog2(H_ACT), $clog2(V_ACT))-1:0] o_pack,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int X_W     = $clog2(H_ACT);
    localparam int Y_W     = $clog2(V_ACT);

    localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C = HC_W'(H_ACT);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACT + H_FP);
    localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C = VC_W'(V_ACT);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACT + V_FP);
    localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACT + V_FP + V_SYNC);

    logic [HC_W-1:0] h_cnt_q, h_cnt_d;
    logic [VC_W-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [23:0]     solid_q, solid_d;
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            h_wrap, v_wrap;
    logic [23:0]     rgb;

    always_comb begin
        h_wrap  = h_cnt_q == H_LAST;
        v_wrap  = v_cnt_q == V_LAST;
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = !h_wrap ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 1'b1;
        de_d    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_d    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_d    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        x_d     = de_d ? h_cnt_q[X_W-1:0] : '0;
        y_d     = de_d ? v_cnt_q[Y_W-1:0] : '0;
        fs_d    = de_d && h_cnt_q == '0 && v_cnt_q == '0;
        // Pattern selection only moves on the last clock of a frame
        mode_d  = (h_wrap && v_wrap) ? i_mode : mode_q;
        solid_d = (h_wrap && v_wrap) ? i_solid_rgb : solid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            mode_q  <= PAT_SOLID;
            solid_q <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    video_pattern_rgb #(
        .H_ACT (H_ACT),
        .HC_W  (HC_W),
        .VC_W  (VC_W)
    ) u_pattern (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt_q),
        .v_cnt     (v_cnt_q),
        .h_wrap    (h_wrap),
        .de        (de_d),
        .mode      (mode_q),
        .solid_rgb (solid_q),
        .rgb       (rgb)
    );

    assign o_pack        = {clk, hs_q, vs_q, de_q, rgb, x_q, y_q};
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: scoreboard bench on a reduced raster so whole frames fit a short run.
module tb_hdmi_timing_gen;

    localparam int HA = 264, HF = 4, HS = 3, HB = 5;
    localparam int VA = 34, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BW = HA / 8;
    localparam int X_W = $clog2(HA);
    localparam int Y_W = $clog2(VA);
    localparam int PW = 28 + X_W + Y_W;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic [23:0]      rgb;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic             fs;
    } exp_t;

    logic          clk, rst;
    logic [1:0]    i_mode;
    logic [23:0]   i_solid_rgb;
    logic [PW-1:0] o_pack;
    logic          o_frame_start;
    logic          o_hs, o_vs, o_de;
    logic [23:0]   o_rgb;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   mh, mv;
    logic [1:0]  mmode;
    logic [23:0] msolid;

    hdmi_timing_gen #(
        .H_ACT(HA), .V_ACT(VA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_mode        (i_mode),
        .i_solid_rgb   (i_solid_rgb),
        .o_pack        (o_pack),
        .o_frame_start (o_frame_start)
    );

    assign o_hs  = o_pack[PW-2];
    assign o_vs  = o_pack[PW-3];
    assign o_de  = o_pack[PW-4];
    assign o_rgb = o_pack[PW-5 -: 24];
    assign o_x   = o_pack[X_W+Y_W-1 : Y_W];
    assign o_y   = o_pack[Y_W-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] model_rgb(int h, int v, logic [1:0] m, logic [23:0] s);
        logic [7:0] r;
        r = h[7:0];
        case (m)
            2'd0: return s;
            2'd1: case (h / BW)
                0: return 24'hFFFFFF;
                1: return 24'hFFFF00;
                2: return 24'h00FFFF;
                3: return 24'h00FF00;
                4: return 24'hFF00FF;
                5: return 24'hFF0000;
                6: return 24'h0000FF;
                default: return 24'h000000;
            endcase
            2'd2: return {r, r, r};
            default: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'h000000 : 24'hFFFFFF;
        endcase
    endfunction

    // Reference raster: expected registered output pushed on every edge
    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (rst) begin
            mh = 0; mv = 0; mmode = 2'd0; msolid = 24'h0;
        end else begin
            e.de  = (mh < HA) && (mv < VA);
            e.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
            e.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
            e.rgb = e.de ? model_rgb(mh, mv, mmode, msolid) : 24'h0;
            e.x   = e.de ? mh[X_W-1:0] : '0;
            e.y   = e.de ? mv[Y_W-1:0] : '0;
            e.fs  = e.de && mh == 0 && mv == 0;
            if (mh == HT - 1 && mv == VT - 1) begin
                mmode = i_mode;
                msolid = i_solid_rgb;
            end
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({o_pack[PW-2:0], o_frame_start} !== e || o_pack[PW-1] !== 1'b0) begin
                miscompares++;
                $display("FAIL stream t=%0t got pack=%h fs=%b expected pack=%h fs=%b",
                         $time, o_pack, o_frame_start, {1'b0, e[PW-1:1]}, e.fs);
            end
        end
    end

    task automatic seek(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= HT * VT + HT && !ok; i++) begin
            if (i > 0) @(negedge clk);
            if (o_de === 1'b1 && o_x == x && o_y == y) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (o_pack[PW-2:0] !== '0 || o_frame_start !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold got pack=%h fs=%b expected 0", o_pack, o_frame_start);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_de !== 1'b1 || o_x !== '0 || o_y !== '0 || o_frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release got de=%b x=%0d y=%0d fs=%b expected 1/0/0/1", o_de, o_x, o_y, o_frame_start);
        end
    endtask

    task automatic test_line;
        bit ok;
        int de_len, hs_rise, hs_fall, period;
        de_len = -1; hs_rise = -1; hs_fall = -1; period = -1;
        seek(0, 1, ok);
        for (int i = 1; i <= HT + 2 && ok && period < 0; i++) begin
            @(negedge clk);
            if (!o_de && de_len < 0) de_len = i;
            if (o_hs && hs_rise < 0) hs_rise = i;
            if (!o_hs && hs_rise >= 0 && hs_fall < 0) hs_fall = i;
            if (o_de && de_len >= 0 && period < 0) period = i;
        end
        vectors += 4;
        if (de_len !== HA) begin miscompares++; $display("FAIL line_de_len got %0d expected %0d", de_len, HA); end
        if (hs_rise !== HA + HF) begin miscompares++; $display("FAIL line_hs_offset got %0d expected %0d", hs_rise, HA + HF); end
        if (hs_fall - hs_rise !== HS) begin miscompares++; $display("FAIL line_hs_width got %0d expected %0d", hs_fall - hs_rise, HS); end
        if (period !== HT) begin miscompares++; $display("FAIL line_period got %0d expected %0d", period, HT); end
    endtask

    task automatic test_frame;
        bit ok;
        int fs_cnt, fs_at, vs_cyc, vs_rise, de_cyc, y_max;
        fs_cnt = 0; fs_at = -1; vs_cyc = 0; vs_rise = -1; de_cyc = 0; y_max = 0;
        i_mode = 2'd1;
        seek(0, 0, ok);
        for (int i = 1; i <= HT * VT && ok; i++) begin
            @(negedge clk);
            if (o_frame_start) begin fs_cnt++; fs_at = i; end
            if (o_vs) vs_cyc++;
            if (o_vs && vs_rise < 0) vs_rise = i;
            if (o_de) begin de_cyc++; if (int'(o_y) > y_max) y_max = int'(o_y); end
        end
        vectors += 6;
        if (fs_cnt !== 1) begin miscompares++; $display("FAIL frame_fs_count got %0d expected 1", fs_cnt); end
        if (fs_at !== HT * VT) begin miscompares++; $display("FAIL frame_period got %0d expected %0d", fs_at, HT * VT); end
        if (de_cyc !== HA * VA) begin miscompares++; $display("FAIL frame_de_cycles got %0d expected %0d", de_cyc, HA * VA); end
        if (y_max !== VA - 1) begin miscompares++; $display("FAIL frame_last_line got %0d expected %0d", y_max, VA - 1); end
        if (vs_cyc !== VS * HT) begin miscompares++; $display("FAIL frame_vs_cycles got %0d expected %0d", vs_cyc, VS * HT); end
        if (vs_rise !== (VA + VF) * HT) begin miscompares++; $display("FAIL frame_vs_start got %0d expected %0d", vs_rise, (VA + VF) * HT); end
    endtask

    task automatic test_bars;
        bit ok;
        int bx[5] = '{0, BW - 1, BW, 7 * BW - 1, HA - 1};
        logic [23:0] bc[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000};
        i_mode = 2'd2;
        for (int k = 0; k < 5; k++) begin
            seek(bx[k], 0, ok);
            vectors++;
            if (!ok || o_rgb !== bc[k]) begin
                miscompares++;
                $display("FAIL bars_x%0d got rgb=%h found=%b expected %h", bx[k], o_rgb, ok, bc[k]);
            end
        end
    endtask

    task automatic test_ramp;
        bit ok;
        int rx[4] = '{0, 255, 256, HA - 1};
        logic [23:0] rc[4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h070707};
        seek(0, 0, ok);
        i_mode = 2'd0;
        i_solid_rgb = 24'h123456;
        for (int k = 0; k < 4; k++) begin
            seek(rx[k], 0, ok);
            vectors++;
            if (!ok || o_rgb !== rc[k]) begin
                miscompares++;
                $display("FAIL ramp_x%0d got rgb=%h found=%b expected %h", rx[k], o_rgb, ok, rc[k]);
            end
        end
    endtask

    task automatic test_mode_switch;
        bit ok;
        seek(0, 0, ok);
        vectors++;
        if (!ok || o_rgb !== 24'h123456) begin miscompares++; $display("FAIL solid_start got rgb=%h expected 123456", o_rgb); end
        seek(0, 20, ok);
        i_mode = 2'd3;
        i_solid_rgb = 24'hABCDEF;
        seek(100, 30, ok);
        vectors++;
        if (!ok || o_rgb !== 24'h123456) begin miscompares++; $display("FAIL solid_after_switch got rgb=%h expected 123456", o_rgb); end
        seek(32, 0, ok);
        vectors++;
        if (!ok || o_rgb !== 24'h000000) begin miscompares++; $display("FAIL checker_32_0 got rgb=%h expected 000000", o_rgb); end
        seek(32, 32, ok);
        vectors++;
        if (!ok || o_rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL checker_32_32 got rgb=%h expected FFFFFF", o_rgb); end
    endtask

    task automatic test_mid_reset;
        bit ok;
        seek(200, 33, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midreset_seek got found=0 expected 1"); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_pack[PW-2:0] !== '0 || o_frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_hold got pack=%h fs=%b expected 0", o_pack, o_frame_start);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_de !== 1'b1 || o_x !== '0 || o_y !== '0 || o_frame_start !== 1'b1 || o_rgb !== 24'h0) begin
            miscompares++;
            $display("FAIL midreset_restart got de=%b x=%0d y=%0d fs=%b rgb=%h expected 1/0/0/1/000000",
                     o_de, o_x, o_y, o_frame_start, o_rgb);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_mode = 2'd0;
        i_solid_rgb = 24'h0;
        test_reset;
        test_line;
        test_frame;
        test_bars;
        test_ramp;
        test_mode_switch;
        test_mid_reset;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
